// File: rtl/sdram_mc_arbiter_if.sv
// SDRAM burst-controller handshake bundle: request/acknowledge pairs, burst
// start address and the channel selects that steer the external FIFO muxes.
interface sdram_mc_arbiter_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned CW = 1
);
  logic          sdram_wr_req;
  logic          sdram_rd_req;
  logic          sdram_wr_ack;
  logic          sdram_rd_ack;
  logic [AW-1:0] sdram_addr;
  logic [CW-1:0] wr_sel;
  logic [CW-1:0] rd_sel;

  // Arbiter side
  modport master (
    output sdram_wr_req, sdram_rd_req, sdram_addr, wr_sel, rd_sel,
    input  sdram_wr_ack, sdram_rd_ack
  );

  // Burst controller / FIFO mux side
  modport slave (
    input  sdram_wr_req, sdram_rd_req, sdram_addr, wr_sel, rd_sel,
    output sdram_wr_ack, sdram_rd_ack
  );
endinterface

// File: rtl/sdram_mc_arbiter.sv
// Multi-channel SDRAM burst arbiter. Round-robin per direction, writes take
// strict priority over reads. Tracks a burst address and frame-done flag per
// channel, with stop-at-end (WRAP=0) or wrap-to-base (WRAP=1) frame handling.
module sdram_mc_arbiter #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned AW        = 24,
  parameter int unsigned LW        = 9,
  parameter int unsigned RDF_DEPTH = 256,
  parameter int unsigned WRAP      = 0,
  localparam int unsigned CW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk_ref,
  input  logic                 rst_n,
  input  logic                 sdram_init_done,
  input  logic [LW-1:0]        wr_length,
  input  logic [LW-1:0]        rd_length,
  input  logic [NUM_CH-1:0]    wr_load,
  input  logic [NUM_CH*AW-1:0] wr_base,
  input  logic [NUM_CH*AW-1:0] wr_max,
  input  logic [NUM_CH-1:0]    rd_load,
  input  logic [NUM_CH*AW-1:0] rd_base,
  input  logic [NUM_CH*AW-1:0] rd_max,
  input  logic [NUM_CH*LW-1:0] wrf_use,
  input  logic [NUM_CH*LW-1:0] rdf_use,
  output logic [NUM_CH-1:0]    rdf_clr,
  output logic [NUM_CH-1:0]    frame_write_done,
  output logic [NUM_CH-1:0]    frame_read_done,
  sdram_mc_arbiter_if.master   sdram
);

  typedef enum logic [2:0] {StIdle, StWReq, StWBusy, StRReq, StRBusy, StUpd} state_e;

  state_e            state_q;
  logic              upd_wr_q;   // UPD belongs to a write burst
  logic              wr_req_q, rd_req_q;
  logic [AW-1:0]     addr_q;
  logic [CW-1:0]     wr_sel_q, rd_sel_q, wr_ptr_q, rd_ptr_q;
  logic [NUM_CH-1:0] wr_load_q, rd_load_q;
  logic [NUM_CH-1:0] wr_pend_q, rd_pend_q;
  logic [NUM_CH-1:0] wr_done_q, rd_done_q;
  logic [NUM_CH-1:0] rdf_clr_q;
  logic [AW-1:0]     wr_addr_q [NUM_CH];
  logic [AW-1:0]     rd_addr_q [NUM_CH];

  logic [NUM_CH-1:0] wr_edge, rd_edge, wr_act, rd_act, wr_elig, rd_elig;
  logic              wr_found, rd_found;
  logic [CW-1:0]     wr_gnt, rd_gnt, wr_ptr_nxt, rd_ptr_nxt;
  int unsigned       wr_idx, rd_idx;

  logic [AW-1:0]     upd_a, upd_base, upd_max;
  logic [LW-1:0]     upd_len;
  logic              upd_pend, upd_fits;
  logic [AW:0]       upd_sum;

  // Load edges and which channel (if any) is owned by the burst in flight
  always_comb begin
    wr_edge = wr_load & ~wr_load_q;
    rd_edge = rd_load & ~rd_load_q;
    wr_act  = '0;
    rd_act  = '0;
    if (state_q == StWReq || state_q == StWBusy || (state_q == StUpd && upd_wr_q)) begin
      wr_act[wr_sel_q] = 1'b1;
    end
    if (state_q == StRReq || state_q == StRBusy || (state_q == StUpd && !upd_wr_q)) begin
      rd_act[rd_sel_q] = 1'b1;
    end
  end

  // Eligibility; a load seen this cycle blocks the channel until its address settles
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_elig[i] = (wrf_use[i*LW +: LW] >= wr_length) && ((WRAP != 0) || !wr_done_q[i]) &&
                   !wr_pend_q[i] && !wr_edge[i];
      rd_elig[i] = (32'(rdf_use[i*LW +: LW]) + 32'(rd_length) <= RDF_DEPTH) &&
                   ((WRAP != 0) || !rd_done_q[i]) && !rd_pend_q[i] && !rd_edge[i];
    end
  end

  // Round-robin search upward from each direction's pointer
  always_comb begin
    wr_found = 1'b0;
    rd_found = 1'b0;
    wr_gnt   = '0;
    rd_gnt   = '0;
    wr_idx   = 0;
    rd_idx   = 0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      wr_idx = (32'(wr_ptr_q) + k) % NUM_CH;
      rd_idx = (32'(rd_ptr_q) + k) % NUM_CH;
      if (!wr_found && wr_elig[wr_idx]) begin
        wr_found = 1'b1;
        wr_gnt   = CW'(wr_idx);
      end
      if (!rd_found && rd_elig[rd_idx]) begin
        rd_found = 1'b1;
        rd_gnt   = CW'(rd_idx);
      end
    end
    wr_ptr_nxt = CW'((32'(wr_gnt) + 1) % NUM_CH);
    rd_ptr_nxt = CW'((32'(rd_gnt) + 1) % NUM_CH);
  end

  // Post-burst address arithmetic for the granted channel
  always_comb begin
    if (upd_wr_q) begin
      upd_a    = wr_addr_q[wr_sel_q];
      upd_len  = wr_length;
      upd_base = wr_base[32'(wr_sel_q)*AW +: AW];
      upd_max  = wr_max[32'(wr_sel_q)*AW +: AW];
      upd_pend = wr_pend_q[wr_sel_q] | wr_edge[wr_sel_q];
    end else begin
      upd_a    = rd_addr_q[rd_sel_q];
      upd_len  = rd_length;
      upd_base = rd_base[32'(rd_sel_q)*AW +: AW];
      upd_max  = rd_max[32'(rd_sel_q)*AW +: AW];
      upd_pend = rd_pend_q[rd_sel_q] | rd_edge[rd_sel_q];
    end
    upd_sum  = {1'b0, upd_a} + (AW+1)'(upd_len);
    upd_fits = upd_sum < {1'b0, upd_max};
  end

  // Arbiter FSM with per-channel address, load and done state
  always_ff @(posedge clk_ref or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      upd_wr_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      addr_q    <= '0;
      wr_sel_q  <= '0;
      rd_sel_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_load_q <= '0;
      rd_load_q <= '0;
      wr_pend_q <= '0;
      rd_pend_q <= '0;
      wr_done_q <= '0;
      rd_done_q <= '0;
      rdf_clr_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        wr_addr_q[i] <= '0;
        rd_addr_q[i] <= '0;
      end
    end else begin
      wr_load_q <= wr_load;
      rd_load_q <= rd_load;
      rdf_clr_q <= '0;

      // Idle channels reload at once; the channel in flight defers to UPD
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_edge[i]) begin
          wr_done_q[i] <= 1'b0;
          if (wr_act[i]) wr_pend_q[i] <= 1'b1;
          else           wr_addr_q[i] <= wr_base[i*AW +: AW];
        end
        if (rd_edge[i]) begin
          rd_done_q[i] <= 1'b0;
          if (rd_act[i]) begin
            rd_pend_q[i] <= 1'b1;
          end else begin
            rd_addr_q[i] <= rd_base[i*AW +: AW];
            rdf_clr_q[i] <= 1'b1;
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (sdram_init_done && wr_found) begin
            state_q  <= StWReq;
            upd_wr_q <= 1'b1;
            wr_req_q <= 1'b1;
            wr_sel_q <= wr_gnt;
            wr_ptr_q <= wr_ptr_nxt;
            addr_q   <= wr_addr_q[wr_gnt];
          end else if (sdram_init_done && rd_found) begin
            state_q  <= StRReq;
            upd_wr_q <= 1'b0;
            rd_req_q <= 1'b1;
            rd_sel_q <= rd_gnt;
            rd_ptr_q <= rd_ptr_nxt;
            addr_q   <= rd_addr_q[rd_gnt];
          end
        end
        StWReq: begin
          if (sdram.sdram_wr_ack) begin
            wr_req_q <= 1'b0;
            state_q  <= StWBusy;
          end
        end
        StRReq: begin
          if (sdram.sdram_rd_ack) begin
            rd_req_q <= 1'b0;
            state_q  <= StRBusy;
          end
        end
        // Entered with ack high, so ack low here is its falling edge
        StWBusy: if (!sdram.sdram_wr_ack) state_q <= StUpd;
        StRBusy: if (!sdram.sdram_rd_ack) state_q <= StUpd;
        StUpd: begin
          state_q <= StIdle;
          if (upd_wr_q) begin
            if (upd_pend) begin
              wr_addr_q[wr_sel_q] <= upd_base;
              wr_pend_q[wr_sel_q] <= 1'b0;
            end else if (upd_fits) begin
              wr_addr_q[wr_sel_q] <= upd_sum[AW-1:0];
              wr_done_q[wr_sel_q] <= 1'b0;
            end else begin
              wr_done_q[wr_sel_q] <= 1'b1;
              if (WRAP != 0) wr_addr_q[wr_sel_q] <= upd_base;
            end
          end else begin
            if (upd_pend) begin
              rd_addr_q[rd_sel_q] <= upd_base;
              rd_pend_q[rd_sel_q] <= 1'b0;
              rdf_clr_q[rd_sel_q] <= 1'b1;
            end else if (upd_fits) begin
              rd_addr_q[rd_sel_q] <= upd_sum[AW-1:0];
              rd_done_q[rd_sel_q] <= 1'b0;
            end else begin
              rd_done_q[rd_sel_q] <= 1'b1;
              if (WRAP != 0) rd_addr_q[rd_sel_q] <= upd_base;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sdram.sdram_wr_req = wr_req_q;
  assign sdram.sdram_rd_req = rd_req_q;
  assign sdram.sdram_addr   = addr_q;
  assign sdram.wr_sel       = wr_sel_q;
  assign sdram.rd_sel       = rd_sel_q;
  assign rdf_clr            = rdf_clr_q;
  assign frame_write_done   = wr_done_q;
  assign frame_read_done    = rd_done_q;

endmodule

// File: tb/tb_sdram_mc_arbiter.sv
// Directed bench for sdram_mc_arbiter: one WRAP=0 and one WRAP=1 instance,
// expected grants queued in a scoreboard and popped as requests appear.
module tb_sdram_mc_arbiter;
  localparam int unsigned AW = 24;
  localparam int unsigned LW = 9;

  typedef struct {
    bit          wr;
    int          ch;
    logic [23:0] addr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        init0, init1;
  logic [8:0]  wr_length, rd_length;
  logic [1:0]  wr_load, rd_load;
  logic [47:0] wr_base, wr_max, rd_base, rd_max;
  logic [17:0] wrf_use, rdf_use;
  logic [1:0]  rdf_clr0, rdf_clr1, wdone0, wdone1, rdone0, rdone1;
  logic        ack_w, ack_r;
  int          tgt;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];

  logic        m_wreq, m_rreq;
  logic [23:0] m_addr;
  logic        m_wsel, m_rsel;
  logic [1:0]  m_rdf_clr, m_wdone;

  sdram_mc_arbiter_if #(.AW(AW), .CW(1)) bus0 ();
  sdram_mc_arbiter_if #(.AW(AW), .CW(1)) bus1 ();

  assign bus0.sdram_wr_ack = ack_w && (tgt == 0);
  assign bus0.sdram_rd_ack = ack_r && (tgt == 0);
  assign bus1.sdram_wr_ack = ack_w && (tgt == 1);
  assign bus1.sdram_rd_ack = ack_r && (tgt == 1);

  sdram_mc_arbiter #(.NUM_CH(2), .AW(AW), .LW(LW), .RDF_DEPTH(256), .WRAP(0)) dut0 (
    .clk_ref(clk), .rst_n(rst_n), .sdram_init_done(init0),
    .wr_length(wr_length), .rd_length(rd_length),
    .wr_load(wr_load), .wr_base(wr_base), .wr_max(wr_max),
    .rd_load(rd_load), .rd_base(rd_base), .rd_max(rd_max),
    .wrf_use(wrf_use), .rdf_use(rdf_use), .rdf_clr(rdf_clr0),
    .frame_write_done(wdone0), .frame_read_done(rdone0), .sdram(bus0)
  );

  sdram_mc_arbiter #(.NUM_CH(2), .AW(AW), .LW(LW), .RDF_DEPTH(256), .WRAP(1)) dut1 (
    .clk_ref(clk), .rst_n(rst_n), .sdram_init_done(init1),
    .wr_length(wr_length), .rd_length(rd_length),
    .wr_load(wr_load), .wr_base(wr_base), .wr_max(wr_max),
    .rd_load(rd_load), .rd_base(rd_base), .rd_max(rd_max),
    .wrf_use(wrf_use), .rdf_use(rdf_use), .rdf_clr(rdf_clr1),
    .frame_write_done(wdone1), .frame_read_done(rdone1), .sdram(bus1)
  );

  always #5 clk = ~clk;

  // Observe whichever instance is currently under test
  always_comb begin
    m_wreq    = (tgt == 1) ? bus1.sdram_wr_req : bus0.sdram_wr_req;
    m_rreq    = (tgt == 1) ? bus1.sdram_rd_req : bus0.sdram_rd_req;
    m_addr    = (tgt == 1) ? bus1.sdram_addr   : bus0.sdram_addr;
    m_wsel    = (tgt == 1) ? bus1.wr_sel       : bus0.wr_sel;
    m_rsel    = (tgt == 1) ? bus1.rd_sel       : bus0.rd_sel;
    m_rdf_clr = (tgt == 1) ? rdf_clr1          : rdf_clr0;
    m_wdone   = (tgt == 1) ? wdone1            : wdone0;
  end

  // Zero burst lengths are illegal stimulus
  always @(posedge clk) begin
    if (rst_n) assert (wr_length != 0 && rd_length != 0) else $fatal(1, "zero burst length");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for a request, score it against the queue, then play a 4-cycle ack.
  // Returns on the idle cycle right after UPD.
  task automatic serve(input bit ld_rd1);
    exp_t e;
    bit   got_wr;
    int   n = 0;
    while (!(m_wreq || m_rreq) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!(m_wreq || m_rreq)) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      return;
    end
    e      = sb.pop_front();
    got_wr = m_wreq;
    chk("grant_dir", {31'd0, got_wr}, {31'd0, e.wr});
    chk("grant_ch", {31'd0, (got_wr ? m_wsel : m_rsel)}, 32'(e.ch));
    chk("grant_addr", {8'd0, m_addr}, {8'd0, e.addr});
    if (got_wr) ack_w = 1'b1;
    else        ack_r = 1'b1;
    @(negedge clk);
    chk("req_drop", {31'd0, m_wreq | m_rreq}, 32'd0);
    if (ld_rd1) rd_load = 2'b10;
    @(negedge clk);
    rd_load = 2'b00;
    if (ld_rd1) chk("rdf_clr_busy", {30'd0, m_rdf_clr}, 32'd0);
    repeat (2) @(negedge clk);
    ack_w = 1'b0;
    ack_r = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic push(input bit wr, input int ch, input logic [23:0] addr);
    exp_t e;
    e.wr   = wr;
    e.ch   = ch;
    e.addr = addr;
    sb.push_back(e);
  endtask

  initial begin
    int n;
    tgt = 0; rst_n = 1'b0; init0 = 1'b0; init1 = 1'b0;
    ack_w = 1'b0; ack_r = 1'b0;
    wr_length = 9'd8; rd_length = 9'd8;
    wr_load = 2'b00; rd_load = 2'b00;
    wr_base = {24'h000100, 24'h000000};
    wr_max  = {24'h000200, 24'h000010};
    rd_base = {24'h002000, 24'h001000};
    rd_max  = {24'h004000, 24'h003000};
    wrf_use = {9'd0, 9'd0};
    rdf_use = {9'd256, 9'd256};
    repeat (2) @(negedge clk);
    chk("rst_wreq", {31'd0, m_wreq}, 32'd0);
    chk("rst_rreq", {31'd0, m_rreq}, 32'd0);
    chk("rst_addr", {8'd0, m_addr}, 32'd0);
    chk("rst_done", {30'd0, m_wdone}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Load all bases; idle channels reload at once and read FIFOs are cleared
    wr_load = 2'b11; rd_load = 2'b11;
    @(negedge clk);
    chk("rdf_clr_load", {30'd0, m_rdf_clr}, 32'h3);
    wr_load = 2'b00; rd_load = 2'b00;
    @(negedge clk);
    chk("rdf_clr_one", {30'd0, m_rdf_clr}, 32'h0);

    // Round robin, then ch0 reaches its frame end and parks
    init0 = 1'b1;
    wrf_use = {9'd8, 9'd8};
    push(1, 0, 24'h000000); push(1, 1, 24'h000100); push(1, 0, 24'h000008);
    push(1, 1, 24'h000108); push(1, 1, 24'h000110);
    serve(0); serve(0); serve(0);
    chk("wdone_stop", {30'd0, m_wdone}, 32'h1);
    serve(0); serve(0);
    wrf_use = {9'd0, 9'd0};
    repeat (4) @(negedge clk);
    chk("idle_no_req", {31'd0, m_wreq | m_rreq}, 32'd0);

    // Reload ch0: done clears and grants resume from base
    wr_load = 2'b01;
    @(negedge clk);
    wr_load = 2'b00;
    chk("wdone_reload", {30'd0, m_wdone}, 32'h0);
    wrf_use = {9'd0, 9'd8};
    push(1, 0, 24'h000000);
    serve(0);

    // Write ch1 and read ch0 eligible together: write first
    wrf_use = {9'd8, 9'd0};
    rdf_use = {9'd256, 9'd0};
    push(1, 1, 24'h000118);
    serve(0);
    wrf_use = {9'd0, 9'd0};
    push(0, 0, 24'h001000);
    serve(0);
    rdf_use = {9'd256, 9'd256};

    // Read ch1 reloaded mid-burst: deferred to UPD, which clears the FIFO
    rdf_use = {9'd0, 9'd256};
    rd_base = {24'h002800, 24'h001000};
    push(0, 1, 24'h002000);
    serve(1);
    chk("rdf_clr_upd", {30'd0, m_rdf_clr}, 32'h2);
    @(negedge clk);
    chk("rdf_clr_pulse", {30'd0, m_rdf_clr}, 32'h0);
    push(0, 1, 24'h002800);
    serve(0);
    rdf_use = {9'd256, 9'd256};

    // Reset during WBUSY discards the burst and its update
    wrf_use = {9'd8, 9'd0};
    n = 0;
    while (!m_wreq && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_sel", {31'd0, m_wsel}, 32'd1);
    chk("pre_rst_addr", {8'd0, m_addr}, 32'h120);
    ack_w = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    ack_w = 1'b0;
    chk("mid_rst_req", {31'd0, m_wreq}, 32'd0);
    chk("mid_rst_sel", {31'd0, m_wsel}, 32'd0);
    chk("mid_rst_addr", {8'd0, m_addr}, 32'd0);
    chk("mid_rst_done", {30'd0, m_wdone}, 32'd0);
    rst_n = 1'b1;
    push(1, 1, 24'h000000);
    serve(0);
    wrf_use = {9'd0, 9'd0};

    // WRAP=1 instance: done pulses at frame end and the address rewinds
    init0 = 1'b0;
    repeat (2) @(negedge clk);
    tgt   = 1;
    init1 = 1'b1;
    wrf_use = {9'd0, 9'd8};
    push(1, 0, 24'h000000); push(1, 0, 24'h000008); push(1, 0, 24'h000000);
    serve(0); serve(0);
    chk("wrap_done_set", {30'd0, m_wdone}, 32'h1);
    serve(0);
    chk("wrap_done_clr", {30'd0, m_wdone}, 32'h0);
    wrf_use = {9'd0, 9'd0};
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
